calc_unit_seq: RTL and testbench

- Clocked, parametrised successor to the two-function calculator datapath.
- W-bit operand registers A and B are loaded from a shared input bus.
- A start/busy/done FSM runs one of four operations: add, subtract, AND, and an iterative unsigned multiply.
- Results land in Z/Zhi with flags; a separate display block consumes A, B, Z.

---
 rtl/calc_pkg.sv | 23 ++
 rtl/shift_add_mul.sv | 50 +++++
 rtl/calc_unit_seq.sv | 136 +++++++++++++
 tb/tb_calc_unit_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types for the sequential calculator: operation encoding and FSM states.
package calc_pkg;

    localparam logic [1:0] OP_ENC_ADD = 2'b00;
    localparam logic [1:0] OP_ENC_SUB = 2'b01;
    localparam logic [1:0] OP_ENC_MUL = 2'b10;
    localparam logic [1:0] OP_ENC_AND = 2'b11;

    typedef enum logic [1:0] {
        OP_ADD = OP_ENC_ADD,
        OP_SUB = OP_ENC_SUB,
        OP_MUL = OP_ENC_MUL,
        OP_AND = OP_ENC_AND
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Radix-2 shift-add unsigned multiplier: go loads operands, then one multiplier bit per edge for W edges.
module shift_add_mul #(
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           CLR_n,
    input  logic           go,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] product,
    output logic           last
);

    localparam int CW = $clog2(W + 1);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic           running;

    // product is the accumulator after this edge's step, so on the last step it is the full result
    assign product = mplier[0] ? acc + mcand : acc;
    assign last    = running && (cnt == CW'(W - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (go) begin
            acc     <= '0;
            mcand   <= {{W{1'b0}}, a};
            mplier  <= b;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            if (last)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/calc_unit_seq.sv
// Clocked four-function calculator (ADD/SUB/MUL/AND) with start/busy/done handshake.
// Optional macro CALC_SAT_EN clamps ADD/SUB results on signed overflow.
module calc_unit_seq
    import calc_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         CLR_n,
    input  logic [W-1:0] in,
    input  logic         loadA,
    input  logic         loadB,
    input  logic [1:0]   op,
    input  logic         C0,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] A,
    output logic [W-1:0] B,
    output logic [W-1:0] Z,
    output logic [W-1:0] Zhi,
    output logic         Cout,
    output logic         ovr,
    output logic         zero
);

    state_t         state;
    op_t            op_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic           c0_q;

    logic [2*W-1:0] mul_product;
    logic           mul_last;
    logic           mul_go;

    logic [W-1:0]   b_eff;
    logic [W:0]     alu_sum;
    logic [W-1:0]   alu_z;
    logic           alu_c;
    logic           alu_v;

    assign mul_go = (state == S_IDLE) && start && (op == OP_ENC_MUL);

    shift_add_mul #(.W(W)) u_mul (
        .CLK     (CLK),
        .CLR_n   (CLR_n),
        .go      (mul_go),
        .a       (A),
        .b       (B),
        .product (mul_product),
        .last    (mul_last)
    );

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        b_eff   = (op_q == OP_SUB) ? ~b_q : b_q;
        alu_sum = {1'b0, a_q} + {1'b0, b_eff} + {{W{1'b0}}, (op_q == OP_SUB) ? 1'b1 : c0_q};
        alu_v   = (a_q[W-1] == b_eff[W-1]) && (alu_sum[W-1] != a_q[W-1]);
        alu_z   = alu_sum[W-1:0];
        alu_c   = alu_sum[W];
        if (op_q == OP_AND) begin
            alu_z = a_q & b_q;
            alu_c = 1'b0;
            alu_v = 1'b0;
        end
`ifdef CALC_SAT_EN
        else if (alu_v) begin
            alu_z = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge CLK or negedge CLR_n) begin
        if (!CLR_n) begin
            state <= S_IDLE;
            op_q  <= OP_ADD;
            a_q   <= '0;
            b_q   <= '0;
            c0_q  <= 1'b0;
            A     <= '0;
            B     <= '0;
            Z     <= '0;
            Zhi   <= '0;
            Cout  <= 1'b0;
            ovr   <= 1'b0;
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (loadA) A <= in;
                    if (loadB) B <= in;
                    if (start) begin
                        // Captures the pre-edge A/B, so a same-edge load does not affect this operation
                        op_q  <= op_t'(op);
                        a_q   <= A;
                        b_q   <= B;
                        c0_q  <= C0;
                        busy  <= 1'b1;
                        state <= (op == OP_ENC_MUL) ? S_MUL : S_EXEC;
                    end
                end
                S_EXEC: begin
                    Z     <= alu_z;
                    Zhi   <= '0;
                    Cout  <= alu_c;
                    ovr   <= alu_v;
                    zero  <= (alu_z == '0);
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_MUL: begin
                    if (mul_last) begin
                        Z     <= mul_product[W-1:0];
                        Zhi   <= mul_product[2*W-1:W];
                        Cout  <= 1'b0;
                        ovr   <= (mul_product[2*W-1:W] != '0);
                        zero  <= (mul_product == '0);
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_unit_seq.sv
// Scoreboard bench for calc_unit_seq: expected results are queued at start and checked when done pulses.
module tb_calc_unit_seq;
    import calc_pkg::*;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] z;
        logic [W-1:0] zhi;
        logic         cout;
        logic         ovr;
        logic         zero;
    } exp_t;

    logic         CLK;
    logic         CLR_n;
    logic [W-1:0] in;
    logic         loadA;
    logic         loadB;
    logic [1:0]   op;
    logic         C0;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] Z;
    logic [W-1:0] Zhi;
    logic         Cout;
    logic         ovr;
    logic         zero;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    logic [W-1:0] ta;
    logic [W-1:0] tb;

    calc_unit_seq #(.W(W)) dut (
        .CLK   (CLK),
        .CLR_n (CLR_n),
        .in    (in),
        .loadA (loadA),
        .loadB (loadB),
        .op    (op),
        .C0    (C0),
        .start (start),
        .busy  (busy),
        .done  (done),
        .A     (A),
        .B     (B),
        .Z     (Z),
        .Zhi   (Zhi),
        .Cout  (Cout),
        .ovr   (ovr),
        .zero  (zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model built on integer/signed arithmetic rather than bit-level carry logic.
    function automatic exp_t model(input op_t o, input logic [W-1:0] a, input logic [W-1:0] b, input logic c0);
        exp_t           r;
        int             u;
        int             s;
        logic [2*W-1:0] p;
        int             smax = (1 << (W - 1)) - 1;
        int             smin = -(1 << (W - 1));
        r.zhi = '0;
        r.cout = 1'b0;
        r.ovr = 1'b0;
        r.z = '0;
        case (o)
            OP_ADD: begin
                u      = int'(a) + int'(b) + int'(c0);
                s      = int'($signed(a)) + int'($signed(b)) + int'(c0);
                r.z    = u[W-1:0];
                r.cout = (u >= (1 << W));
                r.ovr  = (s > smax) || (s < smin);
            end
            OP_SUB: begin
                u      = int'(a) - int'(b);
                s      = int'($signed(a)) - int'($signed(b));
                r.z    = u[W-1:0];
                r.cout = (a >= b);
                r.ovr  = (s > smax) || (s < smin);
            end
            OP_AND: r.z = a & b;
            default: begin
                p     = a * b;
                r.z   = p[W-1:0];
                r.zhi = p[2*W-1:W];
                r.ovr = (r.zhi != '0);
            end
        endcase
`ifdef CALC_SAT_EN
        if (r.ovr && (o == OP_ADD || o == OP_SUB))
            r.z = (s > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
        r.zero = (r.z == '0) && (r.zhi == '0);
        return r;
    endfunction

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge CLK);
        in = a; loadA = 1'b1;
        @(negedge CLK);
        loadA = 1'b0; in = b; loadB = 1'b1;
        @(negedge CLK);
        loadB = 1'b0;
        ta = a; tb = b;
    endtask

    // restart_at: cycle index at which start (and a stray loadA) is pulsed while busy; -1 for none
    task automatic run_op(input string tag, input op_t o, input logic c0, input int restart_at,
                          input bit ld_same, input logic [W-1:0] ld_val);
        exp_t e;
        int   lat;
        @(negedge CLK);
        op = o; C0 = c0; start = 1'b1;
        if (ld_same) begin in = ld_val; loadA = 1'b1; end
        exp_q.push_back(model(o, ta, tb, c0));
        @(negedge CLK);
        start = 1'b0; loadA = 1'b0; lat = 1;
        if (ld_same) ta = ld_val;
        check({tag, " busy"}, busy, 1);
        while (!done && lat < 40) begin
            start = (lat == restart_at);
            loadA = (lat == restart_at);
            in    = ~ta;
            op    = ~o;
            @(negedge CLK);
            lat++;
        end
        start = 1'b0; loadA = 1'b0;
        check({tag, " latency"}, lat, (o == OP_MUL) ? W + 1 : 2);
        e = exp_q.pop_front();
        check({tag, " Z"}, Z, e.z);
        check({tag, " Zhi"}, Zhi, e.zhi);
        check({tag, " Cout"}, Cout, e.cout);
        check({tag, " ovr"}, ovr, e.ovr);
        check({tag, " zero"}, zero, e.zero);
        check({tag, " A"}, A, ta);
        @(negedge CLK);
        check({tag, " done pulse"}, done, 0);
        check({tag, " idle"}, busy, 0);
        check({tag, " Z hold"}, Z, e.z);
    endtask

    initial begin
        CLR_n = 1'b0; in = '0; loadA = 1'b0; loadB = 1'b0;
        op = 2'b00; C0 = 1'b0; start = 1'b0; ta = '0; tb = '0;
        repeat (2) @(negedge CLK);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset AB", {A, B}, 0);
        check("reset Z", {Zhi, Z}, 0);
        check("reset flags", {Cout, ovr, zero}, 3'b001);
        CLR_n = 1'b1;

        load(8'h7F, 8'h01);
        check("load B", B, 8'h01);
        run_op("add ovf", OP_ADD, 1'b0, -1, 1'b0, '0);
        load(8'h3C, 8'hC4);
        run_op("add carry", OP_ADD, 1'b1, -1, 1'b0, '0);

        load(8'h05, 8'h07);
        run_op("sub borrow", OP_SUB, 1'b1, -1, 1'b0, '0);
        load(8'h80, 8'h01);
        run_op("sub ovf", OP_SUB, 1'b0, -1, 1'b0, '0);
        load(8'h42, 8'h42);
        run_op("sub equal", OP_SUB, 1'b0, -1, 1'b0, '0);

        load(8'hFF, 8'hFF);
        run_op("mul ffxff", OP_MUL, 1'b0, 3, 1'b0, '0);
        check("mul ffxff literal", {Zhi, Z}, 16'hFE01);
        load(8'h0D, 8'h0B);
        run_op("mul small", OP_MUL, 1'b0, -1, 1'b0, '0);

        load(8'h0F, 8'hF0);
        run_op("and zero", OP_AND, 1'b1, -1, 1'b0, '0);
        load(8'h0F, 8'h00);
        run_op("mul by zero", OP_MUL, 1'b0, -1, 1'b0, '0);

        load(8'h10, 8'h01);
        run_op("load+start", OP_ADD, 1'b0, -1, 1'b1, 8'h22);
        check("load+start A", A, 8'h22);

        load(8'h03, 8'h05);
        @(negedge CLK);
        op = OP_ENC_MUL; start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #1 CLR_n = 1'b0;
        #1;
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort AB", {A, B}, 0);
        check("abort Z", {Zhi, Z}, 0);
        check("abort flags", {Cout, ovr, zero}, 3'b001);
        @(negedge CLK);
        CLR_n = 1'b1; ta = '0; tb = '0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge CLK);
            check("no residual done", {done, busy}, 0);
        end
        load(8'h21, 8'h12);
        run_op("post-reset add", OP_ADD, 1'b0, -1, 1'b0, '0);

        check("scoreboard empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
